// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared op codes, FSM state encodings and prescaler width for count_sequencer.
package count_seq_pkg;
  typedef logic [1:0] op_t;
  localparam op_t OP_CLEAR = 2'b00;
  localparam op_t OP_LOAD  = 2'b01;
  localparam op_t OP_UP    = 2'b10;
  localparam op_t OP_DOWN  = 2'b11;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int PRESC_W = 16;
endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: valid/ready command channel from the command source to count_sequencer.
interface count_sequencer_if
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/count_sequencer_prescaler.sv
// tick_prescaler: pulses tick_o every TICK_DIV cycles, counting from the cycle after restart_i.
module tick_prescaler
  import count_seq_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);
  logic [PRESC_W-1:0] div_q, div_d;
  assign tick_o = div_q == PRESC_W'(TICK_DIV - 1);
  assign div_d  = (restart_i || tick_o) ? '0 : div_q + PRESC_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else div_q <= div_d;
  end
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: command-driven sequencer for the up/down counter (clear, load, paced stepping).
// Optional TC_STOP_EN: a tick seen while tc_i=1 ends STEP as aborted instead of wrapping.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  count_sequencer_if.slave cmd,
  input  logic             abort_i,
  input  logic             tc_i,
  output logic             cnt_o,
  output logic             dir_o,
  output logic             ld_o,
  output logic             clr_o,
  output logic [WIDTH-1:0] l_o,
  output logic [WIDTH-1:0] shadow_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o
);
  logic [2:0]       state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d, shadow_q, shadow_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             aborted_q, aborted_d;
  logic             accept, tick, in_step, tc_stop, end_ok, end_ab;
`ifdef TC_STOP_EN
  assign tc_stop = tc_i;
`else
  logic unused_tc;
  assign unused_tc = tc_i;
  assign tc_stop   = 1'b0;
`endif
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (accept),
    .tick_o    (tick)
  );
  assign cmd.cmd_ready = state_q == S_IDLE;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign in_step       = state_q == S_STEP;
  // abort and a terminal-count stop both suppress the strobe of the cycle they land in
  assign cnt_o     = in_step && tick && !abort_i && !tc_stop;
  assign dir_o     = in_step && op_q == OP_UP;
  assign ld_o      = state_q == S_LOAD && !abort_i;
  assign clr_o     = state_q == S_CLEAR && !abort_i;
  assign l_o       = ld_o ? ~arg_q : '1;
  assign shadow_o  = shadow_q;
  assign busy_o    = state_q != S_IDLE;
  assign done_o    = state_q == S_DONE;
  assign aborted_o = aborted_q;
  assign end_ok    = clr_o || ld_o || (cnt_o && rem_q == (WIDTH+1)'(1));
  assign end_ab    = (state_q inside {S_CLEAR, S_LOAD, S_STEP} && abort_i) || (in_step && tick && tc_stop);
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    arg_d     = arg_q;
    rem_d     = rem_q;
    shadow_d  = shadow_q;
    aborted_d = 1'b0;
    if (accept) begin
      op_d    = cmd.cmd_op;
      arg_d   = cmd.cmd_arg;
      rem_d   = cmd.cmd_arg == '0 ? {1'b1, {WIDTH{1'b0}}} : {1'b0, cmd.cmd_arg};
      state_d = cmd.cmd_op == OP_CLEAR ? S_CLEAR : cmd.cmd_op == OP_LOAD ? S_LOAD : S_STEP;
    end
    if (clr_o) shadow_d = '0;
    if (ld_o) shadow_d = arg_q;
    if (cnt_o) begin
      shadow_d = dir_o ? shadow_q + WIDTH'(1) : shadow_q - WIDTH'(1);
      rem_d    = rem_q - (WIDTH+1)'(1);
    end
    if (end_ok || end_ab) begin
      state_d   = S_DONE;
      aborted_d = end_ab;
    end
    if (state_q == S_DONE) state_d = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_CLEAR;
      arg_q     <= '0;
      rem_q     <= '0;
      shadow_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      rem_q     <= rem_d;
      shadow_q  <= shadow_d;
      aborted_q <= aborted_d;
    end
  end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: table-driven and scoreboard bench for count_sequencer (TICK_DIV=3).
module tb_count_sequencer;
  import count_seq_pkg::*;
  localparam int W = 4;
  localparam int T = 3;
  localparam int E_CNT = 0, E_LD = 1, E_CLR = 2, E_DONE = 3;
`ifdef TC_STOP_EN
  localparam bit TC_STOP = 1'b1;
`else
  localparam bit TC_STOP = 1'b0;
`endif
  typedef struct {int kind; int cyc; int val; int flag;} ev_t;
  typedef struct {op_t op; logic [3:0] arg; logic [3:0] exp_shadow;} vec_t;
  logic clk = 0, rst_n = 0, abort_i = 0, tc_en = 0;
  logic tc_i, cnt_o, dir_o, ld_o, clr_o, busy_o, done_o, aborted_o;
  logic [W-1:0] l_o, shadow_o, ctr;
  int cyc = 0, tests = 0, fails = 0;
  logic [3:0] model_shadow = 0;
  ev_t q[$];
  vec_t tv[10];
  count_sequencer_if #(.WIDTH(W)) cmd();
  count_sequencer #(.WIDTH(W), .TICK_DIV(T)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .abort_i(abort_i), .tc_i(tc_i),
    .cnt_o(cnt_o), .dir_o(dir_o), .ld_o(ld_o), .clr_o(clr_o), .l_o(l_o),
    .shadow_o(shadow_o), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // stand-in for the external counter, so tc reflects what the real datapath would show
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ctr <= 0;
    else if (clr_o) ctr <= 0;
    else if (ld_o) ctr <= ~l_o;
    else if (cnt_o) ctr <= dir_o ? ctr + 4'd1 : ctr - 4'd1;
  assign tc_i = tc_en && (dir_o ? ctr == 4'hF : ctr == 4'h0);
  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic push(int k, int c, int v, int f);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v; e.flag = f;
    q.push_back(e);
  endtask
  task automatic expect_ev(int k, int v, int f);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected event kind", k, -1);
      return;
    end
    e = q.pop_front();
    chk("event kind", k, e.kind);
    chk("event cycle", cyc, e.cyc);
    chk("event value", v, e.val);
    chk("event flag", f, e.flag);
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("strobe onehot", int'($countones({cnt_o, ld_o, clr_o}) <= 1), 1);
    if (cnt_o) expect_ev(E_CNT, int'(shadow_o), int'(dir_o));
    if (ld_o) expect_ev(E_LD, int'(l_o), 0);
    if (clr_o) expect_ev(E_CLR, 0, 0);
    if (done_o) expect_ev(E_DONE, int'(shadow_o), int'(aborted_o));
  end
  task automatic check_reset(string n);
    chk({n, " cnt"}, cnt_o, 0);
    chk({n, " dir"}, dir_o, 0);
    chk({n, " ld"}, ld_o, 0);
    chk({n, " clr"}, clr_o, 0);
    chk({n, " done"}, done_o, 0);
    chk({n, " aborted"}, aborted_o, 0);
    chk({n, " busy"}, busy_o, 0);
    chk({n, " ready"}, cmd.cmd_ready, 1);
    chk({n, " L"}, l_o, 15);
    chk({n, " shadow"}, shadow_o, 0);
  endtask
  // drives one command, queues its expected event timeline, returns the accept cycle
  task automatic issue(input op_t op, input logic [3:0] arg, input int abort_at, output int a);
    int n;
    logic [3:0] s, la;
    bit ab;
    @(posedge clk); #1;
    cmd.cmd_valid = 1; cmd.cmd_op = op; cmd.cmd_arg = arg;
    a = -1;
    for (int i = 0; i < 300 && a < 0; i++) begin
      @(negedge clk);
      if (cmd.cmd_ready) a = cyc;
    end
    if (a < 0) begin
      chk("accept timeout", 0, 1);
      cmd.cmd_valid = 0;
      return;
    end
    s = model_shadow; ab = 0; la = ~arg;
    if (op == OP_CLEAR || op == OP_LOAD) begin
      if (abort_at == 1) ab = 1;
      else begin
        push(op == OP_LOAD ? E_LD : E_CLR, a + 1, op == OP_LOAD ? int'(la) : 0, 0);
        s = op == OP_LOAD ? arg : 4'd0;
      end
      push(E_DONE, a + 2, int'(s), int'(ab));
    end else begin
      n = arg == 0 ? 16 : int'(arg);
      for (int k = 1; k <= n; k++) begin
        if (k == abort_at || (TC_STOP && tc_en && (op == OP_UP ? s == 4'hF : s == 4'h0))) begin
          ab = 1; n = k;
          break;
        end
        push(E_CNT, a + k * T, int'(s), int'(op == OP_UP));
        s = op == OP_UP ? s + 4'd1 : s - 4'd1;
      end
      push(E_DONE, a + n * T + 1, int'(s), int'(ab));
    end
    model_shadow = s;
    @(posedge clk); #1;
    cmd.cmd_valid = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd.cmd_ready) break;
    end
    chk("idle timeout", cmd.cmd_ready, 1);
  endtask
  initial begin
    int a, a2;
    tv = '{'{OP_LOAD, 4'd9, 4'd9}, '{OP_CLEAR, 4'd0, 4'd0}, '{OP_LOAD, 4'd14, 4'd14},
           '{OP_UP, 4'd3, 4'd1}, '{OP_LOAD, 4'd5, 4'd5}, '{OP_DOWN, 4'd0, 4'd5},
           '{OP_DOWN, 4'd2, 4'd3}, '{OP_UP, 4'd1, 4'd4}, '{OP_LOAD, 4'd0, 4'd0},
           '{OP_DOWN, 4'd1, 4'd15}};
    cmd.cmd_valid = 0; cmd.cmd_op = OP_CLEAR; cmd.cmd_arg = 0;
    #1 check_reset("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      issue(tv[i].op, tv[i].arg, 0, a);
      wait_idle();
      chk($sformatf("vec%0d shadow", i), shadow_o, tv[i].exp_shadow);
    end
    issue(OP_LOAD, 4'd3, 0, a);
    wait_idle();
    issue(OP_UP, 4'd8, 2, a);
    repeat (2 * T - 1) @(posedge clk);
    #1 abort_i = 1;
    @(posedge clk); #1 abort_i = 0;
    wait_idle();
    chk("abort step shadow", shadow_o, 4);
    issue(OP_LOAD, 4'd12, 1, a);
    abort_i = 1;
    @(posedge clk); #1 abort_i = 0;
    wait_idle();
    chk("abort load shadow", shadow_o, 4);
    issue(OP_CLEAR, 4'd0, 0, a);
    @(posedge clk); #1 abort_i = 1;
    @(posedge clk); #1 abort_i = 0;
    wait_idle();
    chk("abort in done shadow", shadow_o, 0);
    abort_i = 1;
    repeat (2) @(negedge clk);
    chk("abort in idle busy", busy_o, 0);
    abort_i = 0;
    issue(OP_UP, 4'd2, 0, a);
    issue(OP_LOAD, 4'd7, 0, a2);
    chk("backpressure accept cycle", a2, a + 2 * T + 2);
    wait_idle();
    chk("backpressure shadow", shadow_o, 7);
    issue(OP_LOAD, 4'd13, 0, a);
    wait_idle();
    tc_en = 1;
    issue(OP_UP, 4'd5, 0, a);
    wait_idle();
    tc_en = 0;
    chk("tc shadow", shadow_o, TC_STOP ? 15 : 2);
    issue(OP_UP, 4'd8, 0, a);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    q.delete();
    model_shadow = 0;
    #1 check_reset("mid-step reset");
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (6) @(negedge clk);
    chk("post-reset ready", cmd.cmd_ready, 1);
    chk("post-reset done", done_o, 0);
    chk("scoreboard empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
